puzzle_regfile_mv: RTL and testbench

Parametrised successor to the puzzle register file: DEPTH x DATA_W array with two combinational read ports, one write port and optional write-to-read bypass. Adds a hardware move engine that locates the blank tile in the board (reg 0), validates a move, then swaps tiles, increments the move counter (reg 1) and appends the direction to the move history (reg 2). Solved status `comp` is computed against a goal board and registered, not hard-wired. Sits between the puzzle controller/solver and the display logic.

---
 rtl/puzzle_regfile_mv_pkg.sv | 36 +++
 rtl/puzzle_regfile_mv_if.sv | 32 +++
 rtl/puzzle_regfile_mv_fsm.sv | 134 +++++++++++++
 rtl/puzzle_regfile_mv.sv | 122 ++++++++++++
 tb/tb_puzzle_regfile_mv.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puzzle_regfile_mv_pkg.sv
// puzzle_pkg: shared types and helpers for the puzzle register file.
//   mv_dir_e      blank-tile move direction as carried on mv_dir
//   mv_state_e    move engine states
//   DEFAULT_BOARD reset / goal board for the 2x3 puzzle
//   tile_at()     extract tile p (row-major, p=0 top-left) from a board
package puzzle_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } mv_dir_e;

    typedef enum logic [2:0] {
        IDLE,
        LOCATE,
        CHECK,
        COMMIT,
        DONE
    } mv_state_e;

    localparam logic [17:0] DEFAULT_BOARD = 18'b001_010_011_100_101_000;

    // Position 0 sits in the most significant tile slot of the board.
    // Supports up to 8 tiles of up to 8 bits each.
    function automatic logic [7:0] tile_at(input logic [63:0] board,
                                           input int unsigned p,
                                           input int unsigned n,
                                           input int unsigned tw);
        logic [63:0] sh;
        sh = board >> ((n - 1 - p) * tw);
        return sh[7:0] & 8'((1 << tw) - 1);
    endfunction

endpackage

// File: rtl/puzzle_regfile_mv_if.sv
// puzzle_regfile_mv_if: move request handshake between the puzzle
// controller (master) and the register file move engine (slave).
//   mv_valid  request, held until mv_ready
//   mv_dir    blank direction: 00 up, 01 down, 10 left, 11 right
//   mv_ready  engine idle
//   mv_done   one-cycle completion pulse
//   mv_ok     qualifies mv_done: 1 = move committed
interface puzzle_regfile_mv_if;

    logic       mv_valid;
    logic [1:0] mv_dir;
    logic       mv_ready;
    logic       mv_done;
    logic       mv_ok;

    modport master (
        output mv_valid,
        output mv_dir,
        input  mv_ready,
        input  mv_done,
        input  mv_ok
    );

    modport slave (
        input  mv_valid,
        input  mv_dir,
        output mv_ready,
        output mv_done,
        output mv_ok
    );

endinterface

// File: rtl/puzzle_regfile_mv_fsm.sv
// puzzle_move_fsm: move engine sequencing for puzzle_regfile_mv.
// Scans the board one position per cycle for the blank tile, checks the
// requested direction against the board edges and presents a one-cycle
// commit strobe with the blank/target positions for the top level to swap.
//   clk, rst_n          clock, async active-low reset
//   board               board bits of reg 0
//   mv_valid, mv_dir    move request
//   mv_ready            engine idle (also gates control-register writes)
//   mv_done, mv_ok      completion pulse and its status
//   commit              high for the COMMIT cycle
//   blank, target       tile positions to swap on commit
//   dir                 latched direction for the move history
module puzzle_move_fsm
    import puzzle_pkg::*;
#(
    parameter  int unsigned ROWS   = 2,
    parameter  int unsigned COLS   = 3,
    parameter  int unsigned TILE_W = 3,
    localparam int unsigned N      = ROWS * COLS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*TILE_W-1:0]   board,
    input  logic                  mv_valid,
    input  logic [1:0]            mv_dir,
    output logic                  mv_ready,
    output logic                  mv_done,
    output logic                  mv_ok,
    output logic                  commit,
    output logic [2:0]            blank,
    output logic [2:0]            target,
    output logic [1:0]            dir
);

    mv_state_e  state;
    mv_dir_e    dir_q;
    logic [2:0] idx;
    logic [2:0] blank_q;
    logic [2:0] target_q;
    logic       ok_q;

    logic        tile_zero;
    logic        legal;
    logic [2:0]  tgt_c;
    int unsigned bi;
    int unsigned row;
    int unsigned col;

    always_comb begin
        tile_zero = (tile_at(64'(board), 32'(idx), N, TILE_W) == 8'd0);
    end

    always_comb begin
        bi    = 32'(blank_q);
        row   = bi / COLS;
        col   = bi % COLS;
        legal = 1'b0;
        tgt_c = blank_q;
        unique case (dir_q)
            UP: begin
                legal = (row > 0);
                tgt_c = 3'(bi - COLS);
            end
            DOWN: begin
                legal = (row < ROWS - 1);
                tgt_c = 3'(bi + COLS);
            end
            LEFT: begin
                legal = (col > 0);
                tgt_c = 3'(bi - 1);
            end
            RIGHT: begin
                legal = (col < COLS - 1);
                tgt_c = 3'(bi + 1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir_q    <= UP;
            idx      <= '0;
            blank_q  <= '0;
            target_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mv_valid) begin
                        dir_q <= mv_dir_e'(mv_dir);
                        idx   <= '0;
                        state <= LOCATE;
                    end
                end
                LOCATE: begin
                    if (tile_zero) begin
                        blank_q <= idx;
                        state   <= CHECK;
                    end else if (idx == 3'(N - 1)) begin
                        ok_q  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                CHECK: begin
                    if (legal) begin
                        target_q <= tgt_c;
                        state    <= COMMIT;
                    end else begin
                        ok_q  <= 1'b0;
                        state <= DONE;
                    end
                end
                COMMIT: begin
                    ok_q  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mv_ready = (state == IDLE);
    assign mv_done  = (state == DONE);
    assign mv_ok    = (state == DONE) && ok_q;
    assign commit   = (state == COMMIT);
    assign blank    = blank_q;
    assign target   = target_q;
    assign dir      = dir_q;

endmodule

// File: rtl/puzzle_regfile_mv.sv
// puzzle_regfile_mv: DEPTH x DATA_W puzzle register file with move engine.
// Reg 0 holds the board, reg 1 the move count, reg 2 the move history.
//   clk, rst_n      clock, async active-low reset
//   we, dst, data   external write port
//   src0/1, data0/1 combinational read ports (optional write bypass)
//   cnt, ord        reg 1 and reg 2
//   comp            registered board == GOAL_BOARD
//   wr_drop         pulse, cycle after a discarded external write
//   mv              move request handshake (slave side)
module puzzle_regfile_mv
    import puzzle_pkg::*;
#(
    parameter  int unsigned         DATA_W      = 40,
    parameter  int unsigned         DEPTH       = 16,
    parameter  int unsigned         ROWS        = 2,
    parameter  int unsigned         COLS        = 3,
    parameter  int unsigned         TILE_W      = 3,
    parameter  logic [DATA_W-1:0]   RESET_BOARD = DATA_W'(DEFAULT_BOARD),
    parameter  logic [DATA_W-1:0]   GOAL_BOARD  = RESET_BOARD,
    parameter  bit                  BYPASS      = 1'b1,
    localparam int unsigned         AW          = $clog2(DEPTH),
    localparam int unsigned         N           = ROWS * COLS,
    localparam int unsigned         BB          = N * TILE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     dst,
    input  logic [DATA_W-1:0] data,
    input  logic [AW-1:0]     src0,
    input  logic [AW-1:0]     src1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] cnt,
    output logic [DATA_W-1:0] ord,
    output logic              comp,
    output logic              wr_drop,
    puzzle_regfile_mv_if.slave mv
);

    localparam int unsigned OW = $clog2(DATA_W);

    logic [DATA_W-1:0] regis [DEPTH];

    logic        idle;
    logic        commit;
    logic [2:0]  blank;
    logic [2:0]  target;
    logic [1:0]  dir;
    logic        drop_c;
    logic        wr_ok;
    logic [OW-1:0]     off_b;
    logic [OW-1:0]     off_t;
    logic [DATA_W-1:0] board_sw;

    puzzle_move_fsm #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .TILE_W (TILE_W)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .board    (regis[0][BB-1:0]),
        .mv_valid (mv.mv_valid),
        .mv_dir   (mv.mv_dir),
        .mv_ready (idle),
        .mv_done  (mv.mv_done),
        .mv_ok    (mv.mv_ok),
        .commit   (commit),
        .blank    (blank),
        .target   (target),
        .dir      (dir)
    );

    assign mv.mv_ready = idle;

    // Control registers 0..2 belong to the engine while a move is in flight.
    assign drop_c = we && (32'(dst) < 3) && !idle;
    assign wr_ok  = we && !drop_c;

    always_comb begin
        data0 = regis[src0];
        if (BYPASS && wr_ok && (dst == src0)) data0 = data;
    end

    always_comb begin
        data1 = regis[src1];
        if (BYPASS && wr_ok && (dst == src1)) data1 = data;
    end

    // The blank holds 0, so swapping both slots is equivalent to moving
    // the target tile into the blank slot and clearing the target slot.
    always_comb begin
        off_b    = OW'((N - 1 - 32'(blank)) * TILE_W);
        off_t    = OW'((N - 1 - 32'(target)) * TILE_W);
        board_sw = regis[0];
        board_sw[off_b +: TILE_W] = regis[0][off_t +: TILE_W];
        board_sw[off_t +: TILE_W] = regis[0][off_b +: TILE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) regis[i] <= '0;
            regis[0] <= RESET_BOARD;
            wr_drop  <= 1'b0;
            comp     <= (RESET_BOARD[BB-1:0] == GOAL_BOARD[BB-1:0]);
        end else begin
            wr_drop <= drop_c;
            comp    <= (regis[0][BB-1:0] == GOAL_BOARD[BB-1:0]);
            if (commit) begin
                regis[0] <= board_sw;
                regis[1] <= regis[1] + DATA_W'(1);
                regis[2] <= {regis[2][DATA_W-3:0], dir};
            end
            if (wr_ok) regis[dst] <= data;
        end
    end

    assign cnt = regis[1];
    assign ord = regis[2];

endmodule

// File: tb/tb_puzzle_regfile_mv.sv
module tb_puzzle_regfile_mv;

    localparam int NT = 6;
    localparam int TW = 3;
    localparam int C  = 3;
    localparam int R  = 2;
    localparam logic [17:0] GOAL = 18'b001_010_011_100_101_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  dst = '0;
    logic [3:0]  src0 = '0;
    logic [3:0]  src1 = '0;
    logic [39:0] data = '0;
    logic [39:0] data0, data1, cnt, ord;
    logic        comp, wr_drop;

    puzzle_regfile_mv_if mv_bus();

    puzzle_regfile_mv #(
        .DATA_W (40),
        .DEPTH  (16),
        .ROWS   (R),
        .COLS   (C),
        .TILE_W (TW),
        .BYPASS (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .dst     (dst),
        .data    (data),
        .src0    (src0),
        .src1    (src1),
        .data0   (data0),
        .data1   (data1),
        .cnt     (cnt),
        .ord     (ord),
        .comp    (comp),
        .wr_drop (wr_drop),
        .mv      (mv_bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [39:0] mreg [16];

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [39:0] data;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [39:0] e0;
        logic [39:0] e1;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: board as tiles, moves by row/column arithmetic.
    function automatic int mtile(input int p);
        logic [39:0] s;
        s = mreg[0] >> ((NT - 1 - p) * TW);
        return int'(s[2:0]);
    endfunction

    function automatic void mset(input int p, input int v);
        int sh;
        sh = (NT - 1 - p) * TW;
        mreg[0] = (mreg[0] & ~(40'h7 << sh)) | (40'(v) << sh);
    endfunction

    function automatic void model_move(input int d, output bit ok, output int lat);
        int  blank;
        int  row, col, tgt;
        bit  legal;
        blank = -1;
        tgt   = 0;
        legal = 1'b0;
        for (int p = 0; p < NT; p++)
            if (blank < 0 && mtile(p) == 0) blank = p;
        if (blank < 0) begin
            ok = 1'b0; lat = NT + 1; return;
        end
        row = blank / C;
        col = blank % C;
        case (d)
            0: begin legal = (row > 0);     tgt = blank - C; end
            1: begin legal = (row < R - 1); tgt = blank + C; end
            2: begin legal = (col > 0);     tgt = blank - 1; end
            default: begin legal = (col < C - 1); tgt = blank + 1; end
        endcase
        if (!legal) begin
            ok = 1'b0; lat = 3 + blank; return;
        end
        mset(blank, mtile(tgt));
        mset(tgt, 0);
        mreg[1] = mreg[1] + 40'd1;
        mreg[2] = {mreg[2][37:0], 2'(d)};
        ok  = 1'b1;
        lat = 4 + blank;
    endfunction

    function automatic logic mcomp();
        return mreg[0][17:0] == GOAL;
    endfunction

    function automatic logic [39:0] rand_board();
        int t [6];
        int j, tmp;
        logic [39:0] b;
        for (int i = 0; i < 6; i++) t[i] = i;
        for (int i = 5; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = t[i]; t[i] = t[j]; t[j] = tmp;
        end
        if ($urandom_range(0, 4) == 0)
            for (int i = 0; i < 6; i++) if (t[i] == 0) t[i] = 6 + $urandom_range(0, 1);
        b = {22'($urandom), 18'd0};
        for (int p = 0; p < 6; p++) b[(5 - p) * 3 +: 3] = 3'(t[p]);
        return b;
    endfunction

    task automatic do_reset();
        we = 1'b0;
        mv_bus.mv_valid = 1'b0;
        src0 = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_board", data0, 40'(GOAL));
        check("rst_cnt", cnt, 40'd0);
        check("rst_ord", ord, 40'd0);
        check("rst_comp", 40'(comp), 40'd1);
        check("rst_ready", 40'(mv_bus.mv_ready), 40'd1);
        check("rst_done", 40'(mv_bus.mv_done), 40'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        mreg[0] = 40'(GOAL);
    endtask

    task automatic do_move(input int d, input bit inject);
        bit eok;
        int elat, k;
        bit seen;
        src0 = '0;
        mv_bus.mv_dir = 2'(d);
        mv_bus.mv_valid = 1'b1;
        #1;
        check("mv_ready", 40'(mv_bus.mv_ready), 40'd1);
        model_move(d, eok, elat);
        step();
        mv_bus.mv_valid = 1'b0;
        k = 1;
        seen = 1'b0;
        while (k <= 30 && !seen) begin
            if (inject) begin
                if (k == 1) begin
                    we = 1'b1; dst = 4'd1; data = 40'd5;
                end else if (k == 2) begin
                    check("wr_drop_pulse", 40'(wr_drop), 40'd1);
                    we = 1'b1; dst = 4'd5; data = 40'd7;
                    mreg[5] = 40'd7;
                end else if (k == 3) begin
                    check("wr_drop_clear", 40'(wr_drop), 40'd0);
                    we = 1'b0; src1 = 4'd5;
                end
            end
            #1;
            if (inject && k == 3) check("wr_other_reg", data1, mreg[5]);
            if (mv_bus.mv_done) seen = 1'b1;
            else begin
                step();
                k++;
            end
        end
        we = 1'b0;
        check("mv_done_seen", 40'(seen), 40'd1);
        if (seen) begin
            check("mv_latency", 40'(k), 40'(elat));
            check("mv_ok", 40'(mv_bus.mv_ok), 40'(eok));
            check("mv_board", data0, mreg[0]);
            check("mv_cnt", cnt, mreg[1]);
            check("mv_ord", ord, mreg[2]);
        end
        step();
        #1;
        check("mv_comp", 40'(comp), 40'(mcomp()));
        check("mv_done_once", 40'(mv_bus.mv_done), 40'd0);
    endtask

    initial begin
        bit seen;
        int r, a;
        logic [39:0] v;

        tbl[0] = '{1'b1, 4'd3,  40'h12345,       4'd3,  4'd0,  40'h12345,       40'(GOAL)};
        tbl[1] = '{1'b1, 4'd4,  40'hABCDE,       4'd3,  4'd4,  40'h12345,       40'hABCDE};
        tbl[2] = '{1'b0, 4'd4,  40'hFFFFF,       4'd4,  4'd3,  40'hABCDE,       40'h12345};
        tbl[3] = '{1'b1, 4'd15, 40'hFF_FFFF_FFFF, 4'd15, 4'd1,  40'hFF_FFFF_FFFF, 40'd0};
        tbl[4] = '{1'b1, 4'd2,  40'h3,           4'd2,  4'd15, 40'h3,           40'hFF_FFFF_FFFF};
        tbl[5] = '{1'b0, 4'd2,  40'h0,           4'd2,  4'd5,  40'h3,           40'd0};

        mv_bus.mv_valid = 1'b0;
        mv_bus.mv_dir   = 2'd0;

        // Reset state
        do_reset();

        // Idle read/write vectors, including same-cycle bypass
        for (int i = 0; i < 6; i++) begin
            we = tbl[i].we; dst = tbl[i].dst; data = tbl[i].data;
            src0 = tbl[i].s0; src1 = tbl[i].s1;
            #1;
            check($sformatf("tbl%0d_data0", i), data0, tbl[i].e0);
            check($sformatf("tbl%0d_data1", i), data1, tbl[i].e1);
            step();
            we = 1'b0;
            if (tbl[i].we) mreg[tbl[i].dst] = tbl[i].data;
            check($sformatf("tbl%0d_nodrop", i), 40'(wr_drop), 40'd0);
        end

        // Legal move up from reset
        do_reset();
        do_move(0, 1'b0);
        check("t2_board", 40'(data0[17:0]), 40'(18'b001_010_000_100_101_011));
        check("t2_cnt", cnt, 40'd1);
        check("t2_ord", ord, 40'd0);

        // Illegal move down from reset
        do_reset();
        do_move(1, 1'b0);
        check("t3_comp", 40'(comp), 40'd1);

        // Counter wrap and move history
        do_reset();
        we = 1'b1; dst = 4'd1; data = '1;
        step();
        we = 1'b0; mreg[1] = '1;
        do_move(0, 1'b0);
        do_move(2, 1'b0);
        check("t4_cnt", cnt, 40'd1);
        check("t4_ord", ord, 40'd2);
        check("t4_board", 40'(data0[17:0]), 40'(18'b001_000_010_100_101_011));
        do_move(3, 1'b0);
        do_move(1, 1'b0);
        check("t4_goal", 40'(comp), 40'd1);

        // Write arbitration during LOCATE
        do_reset();
        do_move(0, 1'b1);

        // Reset in the middle of a move
        do_reset();
        mv_bus.mv_dir = 2'd0;
        mv_bus.mv_valid = 1'b1;
        step();
        mv_bus.mv_valid = 1'b0;
        step();
        step();
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mv_bus.mv_done) seen = 1'b1;
        end
        check("abort_no_done", 40'(seen), 40'd0);
        check("abort_cnt", cnt, 40'd0);
        check("abort_board", data0, 40'(GOAL));

        // Board without a blank
        we = 1'b1; dst = 4'd0; data = 40'(18'b001_010_011_100_101_110);
        step();
        we = 1'b0; mreg[0] = 40'(18'b001_010_011_100_101_110);
        do_move(3, 1'b0);

        // Random writes and moves against the model
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 3);
            if (r == 0) begin
                a = $urandom_range(0, 15);
                if (a == 0) v = rand_board();
                else        v = 40'({$urandom, $urandom});
                we = 1'b1; dst = 4'(a); data = v;
                src0 = 4'($urandom_range(0, 15));
                src1 = 4'($urandom_range(0, 15));
                #1;
                check("rnd_data0", data0, (32'(src0) == a) ? v : mreg[src0]);
                check("rnd_data1", data1, (32'(src1) == a) ? v : mreg[src1]);
                step();
                we = 1'b0;
                mreg[a] = v;
                check("rnd_nodrop", 40'(wr_drop), 40'd0);
            end else begin
                do_move($urandom_range(0, 3), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
